// File: rtl/div_if.sv
// Execute-stage divider handshake: request/operand bus from the controller and
// status/result bus back from the divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic             annul_i;
    logic [WIDTH-1:0] reg1_i;
    logic [WIDTH-1:0] reg2_i;
    logic             busy_o;
    logic             ready_o;
    logic [WIDTH-1:0] lo_o;
    logic [WIDTH-1:0] hi_o;

    modport master (
        output start_i, signed_i, annul_i, reg1_i, reg2_i,
        input  busy_o, ready_o, lo_o, hi_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, reg1_i, reg2_i,
        output busy_o, ready_o, lo_o, hi_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: quotient to LO, remainder to HI,
// one quotient bit per cycle on magnitudes, sign fixed up on the final iteration.
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  resetn,
    div_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    logic [WIDTH:0]   shift_rem;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x,
                                                 input logic is_signed);
        logic signed [WIDTH-1:0] neg;
        neg = -x;
        return (is_signed && x[WIDTH-1]) ? neg : x;
    endfunction

    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] mag,
                                                  input logic negate);
        return negate ? (~mag + 1'b1) : mag;
    endfunction

    // One restoring step: a borrow out of the WIDTH+1-bit trial means "restore".
    always_comb begin
        shift_rem = {rem_q, quo_q[WIDTH-1]};
        trial     = shift_rem - {1'b0, dvs_q};
        quo_next  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_next  = trial[WIDTH] ? shift_rem[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        lo_d      = lo_q;
        hi_d      = hi_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.annul_i && bus.start_i) begin
                    if (bus.reg2_i == '0) begin
                        state_d = S_DONE;
                        lo_d    = '0;
                        hi_d    = '0;
                    end else begin
                        state_d   = S_BUSY;
                        quo_d     = abs_val(bus.reg1_i, bus.signed_i);
                        dvs_d     = abs_val(bus.reg2_i, bus.signed_i);
                        neg_quo_d = bus.signed_i & (bus.reg1_i[WIDTH-1] ^ bus.reg2_i[WIDTH-1]);
                        neg_rem_d = bus.signed_i & bus.reg1_i[WIDTH-1];
                        cnt_d     = '0;
                        rem_d     = '0;
                    end
                end
            end
            S_BUSY: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = quo_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q + 1'b1;
                    // Final iteration: publish sign-corrected results straight from the step logic.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_DONE;
                        lo_d    = sign_fix(quo_next, neg_quo_q);
                        hi_d    = sign_fix(rem_next, neg_rem_q);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
        end
    end

    assign bus.busy_o  = (state_q == S_BUSY);
    assign bus.ready_o = (state_q == S_DONE);
    assign bus.lo_o    = lo_q;
    assign bus.hi_o    = hi_q;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases plus random operands against a plain-arithmetic
// model of MIPS DIV/DIVU (truncating quotient, remainder follows dividend sign).
module tb_div_unit;
    logic clk;
    logic resetn;
    int   tests = 0;
    int   fails = 0;

    div_if #(.WIDTH(32)) ifc ();

    div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sg,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = 0;
            r = 0;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called at a negedge; issues one request and checks latency, busy span, results.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit sg, input logic [31:0] eq, input logic [31:0] er);
        int cyc, bcnt;
        bit got;
        logic [31:0] lo_s, hi_s;
        cyc = 0; bcnt = 0; got = 0; lo_s = 'x; hi_s = 'x;
        ifc.start_i  = 1'b1;
        ifc.signed_i = sg;
        ifc.reg1_i   = a;
        ifc.reg2_i   = b;
        while (!got && cyc < 60) begin
            @(negedge clk);
            if (cyc == 0) begin
                ifc.start_i  = 1'b0;
                ifc.reg1_i   = $urandom;
                ifc.reg2_i   = $urandom;
                ifc.signed_i = 1'($urandom);
            end
            cyc++;
            if (ifc.ready_o) begin
                got  = 1;
                lo_s = ifc.lo_o;
                hi_s = ifc.hi_o;
            end else if (ifc.busy_o) begin
                bcnt++;
            end
        end
        check({tag, ".latency"}, cyc, (b == 0) ? 1 : 33);
        check({tag, ".busy_cycles"}, bcnt, (b == 0) ? 0 : 32);
        check({tag, ".lo"}, lo_s, eq);
        check({tag, ".hi"}, hi_s, er);
        @(negedge clk);
        check({tag, ".ready_pulse"}, 32'(ifc.ready_o), 0);
        check({tag, ".idle_busy"}, 32'(ifc.busy_o), 0);
    endtask

    initial begin
        logic [31:0] a, b, eq, er;
        bit sg;
        int readies, first_rdy;
        logic [31:0] lo_s, hi_s;

        resetn       = 1'b0;
        ifc.start_i  = 1'b0;
        ifc.signed_i = 1'b0;
        ifc.annul_i  = 1'b0;
        ifc.reg1_i   = '0;
        ifc.reg2_i   = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(ifc.busy_o), 0);
        check("rst.ready", 32'(ifc.ready_o), 0);
        check("rst.lo", ifc.lo_o, 0);
        check("rst.hi", ifc.hi_o, 0);
        resetn = 1'b1;
        @(negedge clk);

        do_div("divu_100_7", 100, 7, 0, 14, 2);
        do_div("div_m7_2", 32'hFFFF_FFF9, 2, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("div_7_m2", 7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 1);
        do_div("divu_max_1", 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0);
        do_div("divu_5_0", 5, 0, 0, 0, 0);
        do_div("div_5_0", 5, 0, 1, 0, 0);
        do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
        do_div("divu_maxneg", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000);

        // Annul mid-operation after a completed 100/7
        do_div("pre_annul", 100, 7, 0, 14, 2);
        ifc.start_i = 1'b1; ifc.signed_i = 1'b0; ifc.reg1_i = 1000; ifc.reg2_i = 3;
        @(negedge clk);
        ifc.start_i = 1'b0;
        repeat (9) @(negedge clk);
        ifc.annul_i = 1'b1;
        @(negedge clk);
        ifc.annul_i = 1'b0;
        check("annul.busy", 32'(ifc.busy_o), 0);
        check("annul.ready", 32'(ifc.ready_o), 0);
        check("annul.lo", ifc.lo_o, 14);
        check("annul.hi", ifc.hi_o, 2);
        do_div("post_annul_9_4", 9, 4, 0, 2, 1);

        // annul with start in IDLE drops the request
        ifc.start_i = 1'b1; ifc.annul_i = 1'b1; ifc.reg1_i = 50; ifc.reg2_i = 0;
        @(negedge clk);
        ifc.start_i = 1'b0; ifc.annul_i = 1'b0;
        readies = 0;
        repeat (3) begin
            if (ifc.ready_o || ifc.busy_o) readies++;
            @(negedge clk);
        end
        check("annul_start.dropped", readies, 0);
        check("annul_start.lo_kept", ifc.lo_o, 2);

        // start during BUSY is ignored
        ifc.start_i = 1'b1; ifc.signed_i = 1'b0; ifc.reg1_i = 20; ifc.reg2_i = 6;
        readies = 0; first_rdy = 0; lo_s = 'x; hi_s = 'x;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            ifc.start_i = (c == 5);
            ifc.reg1_i  = 50;
            ifc.reg2_i  = 5;
            if (ifc.ready_o) begin
                readies++;
                if (first_rdy == 0) begin
                    first_rdy = c; lo_s = ifc.lo_o; hi_s = ifc.hi_o;
                end
            end
        end
        check("busy_start.readies", readies, 1);
        check("busy_start.latency", first_rdy, 33);
        check("busy_start.lo", lo_s, 3);
        check("busy_start.hi", hi_s, 2);

        // Asynchronous reset mid-operation
        ifc.start_i = 1'b1; ifc.reg1_i = 1000; ifc.reg2_i = 7;
        @(negedge clk);
        ifc.start_i = 1'b0;
        repeat (19) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("areset.busy", 32'(ifc.busy_o), 0);
        check("areset.ready", 32'(ifc.ready_o), 0);
        check("areset.lo", ifc.lo_o, 0);
        check("areset.hi", ifc.hi_o, 0);
        @(negedge clk);
        resetn = 1'b1;
        readies = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifc.ready_o) readies++;
        end
        check("areset.no_ready", readies, 0);
        do_div("post_reset_9_4", 9, 4, 0, 2, 1);

        // Random operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            b  = $urandom;
            sg = 1'($urandom);
            case (i % 6)
                1: b = 0;
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            ref_div(a, b, sg, eq, er);
            do_div($sformatf("rand%0d", i), a, b, sg, eq, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
